// File: rtl/lut_layer_pkg.sv
// lut_layer_pkg
// Shared types and sizing helpers for the LUT neuron layer.
//   layer_state_t : 2-bit layer controller state
//   calc_nw       : neuron-select width, never below 1 bit
//   calc_depth    : truth-table depth for a given fan-in width
package lut_layer_pkg;

   typedef enum logic [1:0] {
      ST_UNCFG = 2'd0,
      ST_DRAIN = 2'd1,
      ST_LOAD  = 2'd2,
      ST_RUN   = 2'd3
   } layer_state_t;

   function automatic int calc_nw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int calc_depth(input int in_bits);
      return 1 << in_bits;
   endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// lut_neuron_ram
// One neuron truth table: 2**AW entries of DW bits held in distributed RAM.
// Ports:
//   clk          : write clock
//   we           : write strobe (already qualified by the parent's decode)
//   waddr, wdata : write entry and value
//   raddr        : lookup address (asynchronous read)
//   rdata        : lookup result, registered by the parent pipeline
// The array is intentionally not reset so tables survive a layer reset.
module lut_neuron_ram
   import lut_layer_pkg::*;
#(
   parameter int AW = 6,
   parameter int DW = 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   localparam int DEPTH = calc_depth(AW);

   (* ram_style = "distributed", rom_style = "distributed" *)
   logic [DW-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_layer.sv
// lut_neuron_layer
// Runtime-loadable layer of N_NEURONS truth-table neurons behind a
// two-stage valid/ready pipeline. Stage 1 captures the fan-in word, stage 2
// captures the per-neuron table lookups.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready/in_data: upstream beat, neuron n uses [n*IN_BITS +: IN_BITS]
//   out_valid/out_ready/out_data : downstream beat, neuron n at [n*OUT_BITS +: OUT_BITS]
//   cfg_start                : request reload (drains traffic first)
//   cfg_we/cfg_neuron/cfg_addr/cfg_data : table write while loading
//   cfg_commit               : finish loading, start evaluating
//   cfg_ready                : tables may be written
//   loaded                   : layer is evaluating
//   cfg_err                  : sticky flag, write aimed at a nonexistent neuron
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_UNCFG | after reset, tables not trusted, no traffic accepted
// ST_DRAIN | reload requested, flushing in-flight beats downstream
// ST_LOAD  | pipeline empty, host writes tables
// ST_RUN   | tables committed, beats accepted and evaluated
module lut_neuron_layer
   import lut_layer_pkg::*;
#(
   parameter  int N_NEURONS = 16,
   parameter  int IN_BITS   = 6,
   parameter  int OUT_BITS  = 1,
   localparam int NW        = calc_nw(N_NEURONS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [N_NEURONS*OUT_BITS-1:0] out_data,
   input  logic                          cfg_start,
   input  logic                          cfg_we,
   input  logic [NW-1:0]                 cfg_neuron,
   input  logic [IN_BITS-1:0]            cfg_addr,
   input  logic [OUT_BITS-1:0]           cfg_data,
   input  logic                          cfg_commit,
   output logic                          cfg_ready,
   output logic                          loaded,
   output logic                          cfg_err
);

   layer_state_t state, state_nx;

   logic                          v1, v2;
   logic [N_NEURONS*IN_BITS-1:0]  d1;
   logic [N_NEURONS*OUT_BITS-1:0] d2;
   logic [N_NEURONS*OUT_BITS-1:0] lookup;
   logic [N_NEURONS-1:0]          hit;
   logic                          s1_free, s2_free, accept;
   logic                          in_load, start_ok, bad_wr;

   // A stage may load when it is empty or its content moves on this edge.
   assign s2_free  = !v2 || out_ready;
   assign s1_free  = !v1 || s2_free;
   assign accept   = in_valid && in_ready;
   assign in_load  = (state == ST_LOAD);
   assign start_ok = cfg_start && ((state == ST_UNCFG) || (state == ST_RUN));
   // No neuron matched: the index is past the last neuron.
   assign bad_wr   = in_load && cfg_we && !(|hit);

   genvar n;
   generate
      for (n = 0; n < N_NEURONS; n++) begin : g_neuron
         assign hit[n] = (cfg_neuron == NW'(n));

         lut_neuron_ram #(
            .AW (IN_BITS),
            .DW (OUT_BITS)
         ) u_ram (
            .clk   (clk),
            .we    (in_load && cfg_we && hit[n]),
            .waddr (cfg_addr),
            .wdata (cfg_data),
            .raddr (d1[n*IN_BITS +: IN_BITS]),
            .rdata (lookup[n*OUT_BITS +: OUT_BITS])
         );
      end
   endgenerate

   always_comb begin
      state_nx  = state;
      cfg_ready = 1'b0;
      loaded    = 1'b0;
      in_ready  = 1'b0;
      unique case (state)
         ST_UNCFG: begin
            if (cfg_start) state_nx = ST_LOAD;
         end
         ST_RUN: begin
            loaded   = 1'b1;
            in_ready = s1_free;
            if (cfg_start) state_nx = (v1 || v2) ? ST_DRAIN : ST_LOAD;
         end
         ST_DRAIN: begin
            if (!v1 && !v2) state_nx = ST_LOAD;
         end
         ST_LOAD: begin
            cfg_ready = 1'b1;
            if (cfg_commit) state_nx = ST_RUN;
         end
         default: state_nx = ST_UNCFG;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_UNCFG;
         v1      <= 1'b0;
         v2      <= 1'b0;
         d1      <= '0;
         d2      <= '0;
         cfg_err <= 1'b0;
      end else begin
         state <= state_nx;
         if (s1_free) v1 <= accept;
         if (accept)  d1 <= in_data;
         if (s2_free) v2 <= v1;
         // Only capture real lookups so out_data never picks up stale RAM.
         if (s2_free && v1) d2 <= lookup;
         if (start_ok) begin
            cfg_err <= 1'b0;
         end else if (bad_wr) begin
            cfg_err <= 1'b1;
         end
      end
   end

   assign out_valid = v2;
   assign out_data  = d2;

endmodule

// File: tb/tb_lut_neuron_layer.sv
// tb_lut_neuron_layer
// Two layer instances: A (1 neuron, 6-bit fan-in, 1-bit out) and
// B (4 neurons, 4-bit fan-in, 2-bit out). Inputs change on the falling edge,
// outputs are read 1 ns later; transfers happen on the next rising edge.
module tb_lut_neuron_layer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic chk_lat = 1'b0;

   // instance A
   logic       a_rst, a_in_valid, a_out_ready, a_cfg_start, a_cfg_we, a_cfg_commit;
   logic [5:0] a_in_data, a_cfg_addr;
   logic [0:0] a_cfg_neuron, a_cfg_data, a_out_data;
   logic       a_in_ready, a_out_valid, a_cfg_ready, a_loaded, a_cfg_err;
   // instance B
   logic        b_rst, b_in_valid, b_out_ready, b_cfg_start, b_cfg_we, b_cfg_commit;
   logic [15:0] b_in_data;
   logic [7:0]  b_out_data;
   logic [1:0]  b_cfg_neuron, b_cfg_data;
   logic [3:0]  b_cfg_addr;
   logic        b_in_ready, b_out_valid, b_cfg_ready, b_loaded, b_cfg_err;

   logic       model_a [64];
   logic [1:0] model_b [4][16];
   logic [0:0] qa_data [$];
   int         qa_cyc  [$];
   logic [7:0] qb_data [$];
   int         qb_cyc  [$];
   logic       b_stall_prev = 1'b0;
   logic [7:0] b_held;

   lut_neuron_layer #(.N_NEURONS(1), .IN_BITS(6), .OUT_BITS(1)) dut_a (
      .clk(clk), .rst(a_rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .cfg_start(a_cfg_start), .cfg_we(a_cfg_we), .cfg_neuron(a_cfg_neuron),
      .cfg_addr(a_cfg_addr), .cfg_data(a_cfg_data), .cfg_commit(a_cfg_commit),
      .cfg_ready(a_cfg_ready), .loaded(a_loaded), .cfg_err(a_cfg_err)
   );

   lut_neuron_layer #(.N_NEURONS(4), .IN_BITS(4), .OUT_BITS(2)) dut_b (
      .clk(clk), .rst(b_rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .cfg_start(b_cfg_start), .cfg_we(b_cfg_we), .cfg_neuron(b_cfg_neuron),
      .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data), .cfg_commit(b_cfg_commit),
      .cfg_ready(b_cfg_ready), .loaded(b_loaded), .cfg_err(b_cfg_err)
   );

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   function automatic logic [7:0] b_expect(input logic [15:0] d);
      logic [7:0] r;
      logic [3:0] idx;
      r = '0;
      for (int n = 0; n < 4; n++) begin
         idx = d[n*4 +: 4];
         r[n*2 +: 2] = model_b[n][idx];
      end
      return r;
   endfunction

   // ---------------- instance A helpers ----------------
   task automatic a_start();
      a_cfg_start = 1'b1; tick(); a_cfg_start = 1'b0;
   endtask

   task automatic a_commit();
      a_cfg_commit = 1'b1; tick(); a_cfg_commit = 1'b0;
   endtask

   task automatic a_write(input logic [0:0] nsel, input logic [5:0] addr, input logic [0:0] dat);
      a_cfg_we = 1'b1; a_cfg_neuron = nsel; a_cfg_addr = addr; a_cfg_data = dat;
      tick();
      a_cfg_we = 1'b0;
   endtask

   task automatic a_cycle(input logic iv, input logic [5:0] d, input logic ordy, output logic irdy);
      logic [0:0] exp;
      int lat;
      a_in_valid = iv; a_in_data = d; a_out_ready = ordy;
      #1;
      irdy = a_in_ready;
      if (a_out_valid && ordy) begin
         checks++;
         if (qa_data.size() == 0) begin
            errors++;
            $display("FAIL a_spurious_beat out_data=%b expected no beat", a_out_data);
         end else begin
            exp = qa_data.pop_front();
            lat = cyc - qa_cyc.pop_front();
            if (a_out_data !== exp) begin
               errors++;
               $display("FAIL a_out_data got=%b expected=%b", a_out_data, exp);
            end
            if (chk_lat) begin
               checks++;
               if (lat != 2) begin
                  errors++;
                  $display("FAIL a_latency got=%0d expected=2", lat);
               end
            end
         end
      end
      if (iv && irdy) begin
         qa_data.push_back(model_a[d]);
         qa_cyc.push_back(cyc);
      end
      tick();
   endtask

   task automatic a_drain();
      logic irdy;
      for (int i = 0; i < 10 && qa_data.size() != 0; i++) a_cycle(1'b0, 6'd0, 1'b1, irdy);
      checks++;
      if (qa_data.size() != 0) begin
         errors++;
         $display("FAIL a_drain_timeout pending=%0d expected=0", qa_data.size());
         qa_data.delete(); qa_cyc.delete();
      end
   endtask

   task automatic a_sweep();
      logic irdy;
      chk_lat = 1'b1;
      for (int i = 0; i < 64; i++) begin
         a_cycle(1'b1, 6'(i), 1'b1, irdy);
         checks++;
         if (irdy !== 1'b1) begin
            errors++;
            $display("FAIL a_sweep_in_ready beat=%0d got=%b expected=1", i, irdy);
         end
      end
      a_drain();
      chk_lat = 1'b0;
   endtask

   // ---------------- instance B helpers ----------------
   task automatic b_start();
      b_cfg_start = 1'b1; tick(); b_cfg_start = 1'b0;
   endtask

   task automatic b_commit();
      b_cfg_commit = 1'b1; tick(); b_cfg_commit = 1'b0;
   endtask

   task automatic b_write(input logic [1:0] nsel, input logic [3:0] addr, input logic [1:0] dat);
      b_cfg_we = 1'b1; b_cfg_neuron = nsel; b_cfg_addr = addr; b_cfg_data = dat;
      tick();
      b_cfg_we = 1'b0;
   endtask

   task automatic b_cycle(input logic iv, input logic [15:0] d, input logic ordy, output logic irdy);
      logic [7:0] exp;
      int lat;
      b_in_valid = iv; b_in_data = d; b_out_ready = ordy;
      #1;
      irdy = b_in_ready;
      if (b_stall_prev) begin
         checks++;
         if (b_out_valid !== 1'b1 || b_out_data !== b_held) begin
            errors++;
            $display("FAIL b_stall_hold got=%b/%h expected=1/%h", b_out_valid, b_out_data, b_held);
         end
      end
      b_stall_prev = b_out_valid && !ordy;
      b_held       = b_out_data;
      if (b_out_valid && ordy) begin
         checks++;
         if (qb_data.size() == 0) begin
            errors++;
            $display("FAIL b_spurious_beat out_data=%h expected no beat", b_out_data);
         end else begin
            exp = qb_data.pop_front();
            lat = cyc - qb_cyc.pop_front();
            if (b_out_data !== exp) begin
               errors++;
               $display("FAIL b_out_data got=%h expected=%h", b_out_data, exp);
            end
            if (chk_lat) begin
               checks++;
               if (lat != 2) begin
                  errors++;
                  $display("FAIL b_latency got=%0d expected=2", lat);
               end
            end
         end
      end
      if (iv && irdy) begin
         qb_data.push_back(b_expect(d));
         qb_cyc.push_back(cyc);
      end
      tick();
   endtask

   task automatic b_drain();
      logic irdy;
      for (int i = 0; i < 10 && qb_data.size() != 0; i++) b_cycle(1'b0, 16'd0, 1'b1, irdy);
      checks++;
      if (qb_data.size() != 0) begin
         errors++;
         $display("FAIL b_drain_timeout pending=%0d expected=0", qb_data.size());
         qb_data.delete(); qb_cyc.delete();
      end
      b_stall_prev = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      a_rst = 1'b1; b_rst = 1'b1;
      tick(); tick();
      a_rst = 1'b0; b_rst = 1'b0;
      #1;
      checks++;
      if ({a_loaded, a_in_ready, a_out_valid, a_out_data, a_cfg_ready, a_cfg_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_a_outputs got=%b expected=000000",
                  {a_loaded, a_in_ready, a_out_valid, a_out_data, a_cfg_ready, a_cfg_err});
      end
      checks++;
      if ({b_loaded, b_in_ready, b_out_valid, b_out_data, b_cfg_ready, b_cfg_err} !== 13'b0) begin
         errors++;
         $display("FAIL reset_b_outputs got=%b expected=0",
                  {b_loaded, b_in_ready, b_out_valid, b_out_data, b_cfg_ready, b_cfg_err});
      end
      a_in_valid = 1'b1; a_in_data = 6'h2a; a_out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(); #1;
         checks++;
         if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept cycle=%0d in_ready=%b out_valid=%b expected 0/0",
                     i, a_in_ready, a_out_valid);
         end
      end
      a_in_valid = 1'b0;
      a_commit();
      #1;
      checks++;
      if (a_loaded !== 1'b0) begin
         errors++;
         $display("FAIL uncfg_commit_ignored loaded=%b expected=0", a_loaded);
      end
   endtask

   task automatic test_single_lookup();
      a_start();
      #1;
      checks++;
      if (a_cfg_ready !== 1'b1 || a_loaded !== 1'b0) begin
         errors++;
         $display("FAIL a_enter_load cfg_ready=%b loaded=%b expected 1/0", a_cfg_ready, a_loaded);
      end
      for (int i = 0; i < 64; i++) begin
         a_write(1'b0, 6'(i), 1'b1);
         model_a[i] = 1'b1;
      end
      a_write(1'b0, 6'd3, 1'b0);  model_a[3]  = 1'b0;
      a_write(1'b0, 6'd49, 1'b0); model_a[49] = 1'b0;
      a_write(1'b0, 6'd63, 1'b0); model_a[63] = 1'b0;
      a_commit();
      #1;
      checks++;
      if (a_loaded !== 1'b1 || a_in_ready !== 1'b1 || a_cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL a_enter_run loaded=%b in_ready=%b cfg_ready=%b expected 1/1/0",
                  a_loaded, a_in_ready, a_cfg_ready);
      end
      a_sweep();
   endtask

   task automatic test_throughput();
      logic irdy;
      b_start();
      for (int n = 0; n < 4; n++) begin
         for (int a = 0; a < 16; a++) begin
            b_write(2'(n), 4'(a), 2'((a + n) % 4));
            model_b[n][a] = 2'((a + n) % 4);
         end
      end
      b_commit();
      chk_lat = 1'b1;
      for (int i = 0; i < 256; i++) begin
         b_cycle(1'b1, 16'($urandom), 1'b1, irdy);
         checks++;
         if (irdy !== 1'b1) begin
            errors++;
            $display("FAIL b_throughput_in_ready beat=%0d got=%b expected=1", i, irdy);
         end
      end
      b_drain();
      chk_lat = 1'b0;
   endtask

   task automatic test_backpressure();
      logic irdy, exp_rdy, ordy;
      logic [15:0] d;
      logic [3:0] pat;
      pat = 4'b1001;
      d = 16'($urandom);
      for (int i = 0; i < 48; i++) begin
         ordy    = pat[3 - (i % 4)];
         exp_rdy = (qb_data.size() < 2) || ordy;
         b_cycle(1'b1, d, ordy, irdy);
         checks++;
         if (irdy !== exp_rdy) begin
            errors++;
            $display("FAIL bp_in_ready cycle=%0d got=%b expected=%b", i, irdy, exp_rdy);
         end
         if (irdy) d = 16'($urandom);
      end
      b_drain();
   endtask

   task automatic test_reload();
      logic irdy;
      int waited;
      b_cycle(1'b1, 16'h1234, 1'b0, irdy);
      b_cycle(1'b1, 16'hfedc, 1'b0, irdy);
      b_in_valid = 1'b0;
      b_cfg_start = 1'b1;
      #1;
      checks++;
      if (b_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reload_full_stall in_ready=%b expected=0", b_in_ready);
      end
      tick();
      b_cfg_start = 1'b0;
      #1;
      checks++;
      if (b_in_ready !== 1'b0 || b_cfg_ready !== 1'b0 || b_loaded !== 1'b0) begin
         errors++;
         $display("FAIL reload_drain in_ready=%b cfg_ready=%b loaded=%b expected 0/0/0",
                  b_in_ready, b_cfg_ready, b_loaded);
      end
      waited = 0;
      while (b_cfg_ready !== 1'b1 && waited < 12) begin
         b_cycle(1'b1, 16'($urandom), 1'b1, irdy);
         waited++;
         checks++;
         if (irdy !== 1'b0) begin
            errors++;
            $display("FAIL reload_drain_in_ready got=%b expected=0", irdy);
         end
      end
      b_in_valid = 1'b0;
      #1;
      checks++;
      if (b_cfg_ready !== 1'b1 || qb_data.size() != 0) begin
         errors++;
         $display("FAIL reload_reach_load cfg_ready=%b pending=%0d expected 1/0",
                  b_cfg_ready, qb_data.size());
         qb_data.delete(); qb_cyc.delete();
      end
      b_stall_prev = 1'b0;
      for (int n = 0; n < 4; n++) begin
         for (int a = 0; a < 16; a++) begin
            b_write(2'(n), 4'(a), 2'd0);
            model_b[n][a] = 2'd0;
         end
      end
      b_commit();
      for (int i = 0; i < 8; i++) b_cycle(1'b1, 16'($urandom) | 16'h5555, 1'b1, irdy);
      b_drain();
   endtask

   task automatic test_errors();
      a_write(1'b0, 6'd0, 1'b0);   // in RUN: must be ignored
      a_start();
      #1;
      checks++;
      if (a_cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL err_initial cfg_err=%b expected=0", a_cfg_err);
      end
      a_write(1'b1, 6'd3, 1'b1);   // neuron index 1 does not exist
      #1;
      checks++;
      if (a_cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL err_set cfg_err=%b expected=1", a_cfg_err);
      end
      a_write(1'b0, 6'd5, 1'b0); model_a[5] = 1'b0;
      a_commit();
      #1;
      checks++;
      if (a_cfg_err !== 1'b1 || a_loaded !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky cfg_err=%b loaded=%b expected 1/1", a_cfg_err, a_loaded);
      end
      a_sweep();
      a_start();
      #1;
      checks++;
      if (a_cfg_err !== 1'b0 || a_cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL err_clear_on_start cfg_err=%b cfg_ready=%b expected 0/1", a_cfg_err, a_cfg_ready);
      end
      a_write(1'b1, 6'd7, 1'b0);
      a_write(1'b0, 6'd10, 1'b0); model_a[10] = 1'b0;
      a_rst = 1'b1; tick(); a_rst = 1'b0;
      #1;
      checks++;
      if ({a_loaded, a_cfg_ready, a_cfg_err, a_in_ready} !== 4'b0) begin
         errors++;
         $display("FAIL rst_mid_load got=%b expected=0000", {a_loaded, a_cfg_ready, a_cfg_err, a_in_ready});
      end
      a_start();
      a_commit();
      a_sweep();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      a_rst = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b0; a_cfg_start = 1'b0;
      a_cfg_we = 1'b0; a_cfg_commit = 1'b0; a_in_data = '0; a_cfg_addr = '0;
      a_cfg_neuron = '0; a_cfg_data = '0;
      b_rst = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b0; b_cfg_start = 1'b0;
      b_cfg_we = 1'b0; b_cfg_commit = 1'b0; b_in_data = '0; b_cfg_addr = '0;
      b_cfg_neuron = '0; b_cfg_data = '0;
      tick();
      test_reset();
      test_single_lookup();
      test_throughput();
      test_backpressure();
      test_reload();
      test_errors();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
